id_exe_pipe: RTL and testbench
==============================

// Module: id_exe_pipe
// PURPOSE
// - Parametrised ID->EXE pipeline stage. Replaces a fixed hold-only register with a valid/ready
//   handshake, a 2-entry skid buffer, flush, bubble insertion and table-driven operand muxing.
// - Sits between the decoder/regfile read and the ALU. It presents op1/op2/mem_write_value, the
//   control bits and opn/pc to EXE.
// PARAMETERS
// - DATA_W   16       operand/pc width; must be >= 16; immediates are extended to DATA_W
// - ADDR_W   4        register address width
// - NOP_OPN  16'h0800 opcode driven on opn_out for an empty stage or a bubble
// PORTS
// - clk            in   1       clock, rising edge
// - rst            in   1       reset; asynchronous, active-high
// - in_valid       in   1       ID presents an instruction
// - in_ready       out  1       stage can accept; registered, equals !skid_valid
// - flush          in   1       squash all held entries (branch/exception)
// - bubble         in   1       hazard stall: drop this cycle's input and insert NOP
// - opn            in   16      instruction word
// - pc             in   DATA_W  pc of the instruction
// - read_value1/2  in   DATA_W  regfile read ports
// - op1_sel        in   2       0 rv1, 1 rv2, 2 pc, 3 zero
// - op2_sel        in   3       0 rv2, 1 sext(opn[7:0]), 2 zext(opn[7:0]), 3 zext(opn[4:2]),
//                               4 sext(opn[3:0]), 5 sext(opn[10:0]), 6 zero, 7 rv1
// - mem_write, mem_read, reg_write  in 1 each; reg_addr in ADDR_W
// - out_valid      out  1       EXE entry valid
// - out_ready      in   1       EXE consumes the entry
// - op1, op2, mem_write_value, pc_out  out DATA_W;  opn_out out 16
// - mem_write_out, mem_read_out, reg_write_out out 1;  reg_addr_out out ADDR_W
// BEHAVIOUR
// - Reset (asynchronous): main and skid entries invalid; every data output 0; opn_out=NOP_OPN;
//   out_valid=0; in_ready=1.
// - Accept: accept = in_valid & in_ready & !bubble & !flush. The operands are resolved at accept.
//   mem_write_value is set to the resolved rv2. The entry reaches the outputs at the next edge,
//   so latency is 1 cycle.
// - Drain: drain = out_valid & out_ready.
//   - On drain, the skid entry (if valid) moves to main; otherwise main takes the accepted entry
//     or goes empty.
//   - Accept while main is valid and there is no drain: the entry goes into skid, and in_ready
//     drops on the next cycle.
//   - Accept and drain in the same cycle with skid empty: main is replaced directly; throughput
//     is 1 per cycle.
// - flush has the highest priority: both entries become invalid at the edge, the input is
//   ignored, and outputs return to reset values (opn_out=NOP_OPN). flush together with out_ready
//   is still only a flush.
// - bubble: the input is not accepted. It does not disturb held entries. If main drains with
//   skid empty, the stage goes empty (NOP).
// - When the stage is empty (out_valid=0), the control outputs are forced to 0 and
//   opn_out=NOP_OPN, so EXE never performs a write.
// - Held-entry outputs stay stable while out_valid & !out_ready.
// - Extensions: sext replicates the top bit of the field up to DATA_W; zext zero-fills.
// CONFIGURATION
// - ID_EXE_FWD_EN defined: adds the ports below.
//   - rs1_addr, rs2_addr        in ADDR_W
//   - fwd_exe_valid, fwd_mem_valid  in 1
//   - fwd_exe_addr, fwd_mem_addr    in ADDR_W
//   - fwd_exe_value, fwd_mem_value  in DATA_W
//   - At accept, rv1 and rv2 are replaced by a forwarded value when the valid bit is set and the
//     address matches. EXE takes priority over MEM. Forwarding is applied at capture only;
//     downstream stalls freeze the producers.
// - ID_EXE_FWD_EN undefined: the ports are absent and read_value1/2 are used as-is.
// TESTING
// - rst pulse mid-stream -> same cycle: out_valid=0, opn_out=0x0800, in_ready=1, op1=op2=0.
// - Sequence opn=0x4A85 (ADDIU, rv1=0x0010, op1_sel=0, op2_sel=1), then 0x6D7F
//   (LI, op1_sel=2 gives pc; instead use op2_sel=2 with op1_sel=3), out_ready=1
//   -> cycle 1: op1=0x0010, op2=0xFF85; cycle 2: op1=0x0000, op2=0x007F.
// - Backpressure: out_ready=0 while 3 back-to-back valid inputs arrive -> the first is held, the
//   second goes to skid, in_ready=0, and the third is stalled upstream. Release -> all three
//   appear in order with none lost or duplicated.
// - flush with main and skid both full plus in_valid=1 -> next edge: out_valid=0,
//   opn_out=0x0800, reg_write_out=0, in_ready=1.
// - bubble=1 with in_valid=1 and an empty stage -> out_valid stays 0 and the input is not
//   consumed (in_ready is high but accept=0).
// - ID_EXE_FWD_EN: rs1_addr=3 with fwd_exe(3,0x1234) and fwd_mem(3,0x5678) -> op1=0x1234.
//   The same test with only the MEM match -> op1=0x5678.

Source files
------------

// File: rtl/id_exe_pipe.sv
// ID->EXE pipeline stage: valid/ready handshake, 2-entry skid buffer, flush, bubble and operand muxing.
// Optional operand forwarding at capture is enabled by defining ID_EXE_FWD_EN.
module id_exe_pipe #(
  parameter int          DATA_W  = 16,
  parameter int          ADDR_W  = 4,
  parameter logic [15:0] NOP_OPN = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              bubble,
  input  logic [15:0]       opn,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] read_value1,
  input  logic [DATA_W-1:0] read_value2,
  input  logic [1:0]        op1_sel,
  input  logic [2:0]        op2_sel,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] reg_addr,
`ifdef ID_EXE_FWD_EN
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              fwd_exe_valid,
  input  logic              fwd_mem_valid,
  input  logic [ADDR_W-1:0] fwd_exe_addr,
  input  logic [ADDR_W-1:0] fwd_mem_addr,
  input  logic [DATA_W-1:0] fwd_exe_value,
  input  logic [DATA_W-1:0] fwd_mem_value,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] mem_write_value,
  output logic [DATA_W-1:0] pc_out,
  output logic [15:0]       opn_out,
  output logic              mem_write_out,
  output logic              mem_read_out,
  output logic              reg_write_out,
  output logic [ADDR_W-1:0] reg_addr_out
);

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] mwv;
    logic [DATA_W-1:0] pc;
    logic [15:0]       opn;
    logic              mem_write;
    logic              mem_read;
    logic              reg_write;
    logic [ADDR_W-1:0] reg_addr;
  } entry_t;

  localparam entry_t EMPTY_ENTRY = '{op1: '0, op2: '0, mwv: '0, pc: '0, opn: NOP_OPN,
                                     mem_write: 1'b0, mem_read: 1'b0, reg_write: 1'b0,
                                     reg_addr: '0};

  entry_t            main_q;
  entry_t            skid_q;
  logic              main_valid;
  logic              skid_valid;
  entry_t            new_entry;
  logic [DATA_W-1:0] rv1;
  logic [DATA_W-1:0] rv2;
  logic [DATA_W-1:0] op1_res;
  logic [DATA_W-1:0] op2_res;
  logic              accept;
  logic              drain;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is a register (!skid_valid), so upstream never sees a combinational path.
  assign in_ready = !skid_valid;
  assign accept   = in_valid & in_ready & !bubble & !flush;
  assign drain    = main_valid & out_ready;

`ifdef ID_EXE_FWD_EN
  // EXE result is younger than MEM, so it wins when both match.
  always_comb begin
    rv1 = read_value1;
    rv2 = read_value2;
    if (fwd_exe_valid && fwd_exe_addr == rs1_addr)      rv1 = fwd_exe_value;
    else if (fwd_mem_valid && fwd_mem_addr == rs1_addr) rv1 = fwd_mem_value;
    if (fwd_exe_valid && fwd_exe_addr == rs2_addr)      rv2 = fwd_exe_value;
    else if (fwd_mem_valid && fwd_mem_addr == rs2_addr) rv2 = fwd_mem_value;
  end
`else
  assign rv1 = read_value1;
  assign rv2 = read_value2;
`endif

  always_comb begin
    op1_res = '0;
    case (op1_sel)
      2'd0:    op1_res = rv1;
      2'd1:    op1_res = rv2;
      2'd2:    op1_res = pc;
      default: op1_res = '0;
    endcase
  end

  always_comb begin
    op2_res = '0;
    case (op2_sel)
      3'd0:    op2_res = rv2;
      3'd1:    op2_res = {{(DATA_W-8){opn[7]}}, opn[7:0]};
      3'd2:    op2_res = {{(DATA_W-8){1'b0}}, opn[7:0]};
      3'd3:    op2_res = {{(DATA_W-3){1'b0}}, opn[4:2]};
      3'd4:    op2_res = {{(DATA_W-4){opn[3]}}, opn[3:0]};
      3'd5:    op2_res = {{(DATA_W-11){opn[10]}}, opn[10:0]};
      3'd6:    op2_res = '0;
      default: op2_res = rv1;
    endcase
  end

  always_comb begin
    new_entry           = EMPTY_ENTRY;
    new_entry.op1       = op1_res;
    new_entry.op2       = op2_res;
    new_entry.mwv       = rv2;
    new_entry.pc        = pc;
    new_entry.opn       = opn;
    new_entry.mem_write = mem_write;
    new_entry.mem_read  = mem_read;
    new_entry.reg_write = reg_write;
    new_entry.reg_addr  = reg_addr;
  end

  // Accept is impossible while skid is full, so a drain with skid valid never needs to
  // capture new input at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= EMPTY_ENTRY;
      skid_q     <= EMPTY_ENTRY;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= EMPTY_ENTRY;
      skid_q     <= EMPTY_ENTRY;
    end else if (drain) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_q <= new_entry;
      end
    end else if (!main_valid) begin
      main_valid <= accept;
      if (accept) main_q <= new_entry;
    end else if (accept) begin
      skid_q     <= new_entry;
      skid_valid <= 1'b1;
    end
  end

  // An empty stage looks exactly like reset to EXE: zero data, no writes, NOP opcode.
  assign out_valid       = main_valid;
  assign op1             = main_valid ? main_q.op1 : '0;
  assign op2             = main_valid ? main_q.op2 : '0;
  assign mem_write_value = main_valid ? main_q.mwv : '0;
  assign pc_out          = main_valid ? main_q.pc  : '0;
  assign opn_out         = main_valid ? main_q.opn : NOP_OPN;
  assign mem_write_out   = main_valid & main_q.mem_write;
  assign mem_read_out    = main_valid & main_q.mem_read;
  assign reg_write_out   = main_valid & main_q.reg_write;
  assign reg_addr_out    = main_valid ? main_q.reg_addr : '0;

endmodule

// File: tb/tb_id_exe_pipe.sv
// Directed bench for id_exe_pipe: reset, operand muxing, backpressure, flush, bubble, forwarding.
module tb_id_exe_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        bubble = 1'b0;
  logic [15:0] opn = '0;
  logic [15:0] pc = '0;
  logic [15:0] read_value1 = '0;
  logic [15:0] read_value2 = '0;
  logic [1:0]  op1_sel = '0;
  logic [2:0]  op2_sel = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic        reg_write = 1'b0;
  logic [3:0]  reg_addr = '0;
`ifdef ID_EXE_FWD_EN
  logic [3:0]  rs1_addr = '0;
  logic [3:0]  rs2_addr = '0;
  logic        fwd_exe_valid = 1'b0;
  logic        fwd_mem_valid = 1'b0;
  logic [3:0]  fwd_exe_addr = '0;
  logic [3:0]  fwd_mem_addr = '0;
  logic [15:0] fwd_exe_value = '0;
  logic [15:0] fwd_mem_value = '0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [15:0] mem_write_value;
  logic [15:0] pc_out;
  logic [15:0] opn_out;
  logic        mem_write_out;
  logic        mem_read_out;
  logic        reg_write_out;
  logic [3:0]  reg_addr_out;

  int n_vec = 0;
  int n_err = 0;

  id_exe_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .bubble(bubble), .opn(opn), .pc(pc), .read_value1(read_value1),
    .read_value2(read_value2), .op1_sel(op1_sel), .op2_sel(op2_sel),
    .mem_write(mem_write), .mem_read(mem_read), .reg_write(reg_write), .reg_addr(reg_addr),
`ifdef ID_EXE_FWD_EN
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .fwd_exe_valid(fwd_exe_valid),
    .fwd_mem_valid(fwd_mem_valid), .fwd_exe_addr(fwd_exe_addr), .fwd_mem_addr(fwd_mem_addr),
    .fwd_exe_value(fwd_exe_value), .fwd_mem_value(fwd_mem_value),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2),
    .mem_write_value(mem_write_value), .pc_out(pc_out), .opn_out(opn_out),
    .mem_write_out(mem_write_out), .mem_read_out(mem_read_out),
    .reg_write_out(reg_write_out), .reg_addr_out(reg_addr_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] o, input logic [15:0] p, input logic [15:0] r1,
                       input logic [15:0] r2, input logic [1:0] s1, input logic [2:0] s2,
                       input logic mw, input logic rw);
    opn = o; pc = p; read_value1 = r1; read_value2 = r2;
    op1_sel = s1; op2_sel = s2; mem_write = mw; reg_write = rw;
    mem_read = 1'b0; reg_addr = o[3:0];
  endtask

  // expected op2 for opn=0x0D9C, rv1=0x1111, rv2=0x2222, per op2_sel
  logic [15:0] exp_op2 [8];
  logic [15:0] exp_op1 [4];

  initial begin
    exp_op2[0] = 16'h2222; exp_op2[1] = 16'hFF9C; exp_op2[2] = 16'h009C; exp_op2[3] = 16'h0007;
    exp_op2[4] = 16'hFFFC; exp_op2[5] = 16'hFD9C; exp_op2[6] = 16'h0000; exp_op2[7] = 16'h1111;
    exp_op1[0] = 16'h1111; exp_op1[1] = 16'h2222; exp_op1[2] = 16'h0042; exp_op1[3] = 16'h0000;

    #1 rst = 1'b1;
    #2;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_opn_out", {16'd0, opn_out}, 32'h0800);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_op1", {16'd0, op1}, 32'd0);
    check_eq("rst_reg_write", {31'd0, reg_write_out}, 32'd0);
    step(); step();
    rst = 1'b0;

    // ADDIU then LI, streaming with out_ready=1
    out_ready = 1'b1; in_valid = 1'b1;
    drive(16'h4A85, 16'h0100, 16'h0010, 16'h00AA, 2'd0, 3'd1, 1'b0, 1'b1);
    step();
    check_eq("addiu_valid", {31'd0, out_valid}, 32'd1);
    check_eq("addiu_op1", {16'd0, op1}, 32'h0010);
    check_eq("addiu_op2", {16'd0, op2}, 32'hFF85);
    check_eq("addiu_mwv", {16'd0, mem_write_value}, 32'h00AA);
    check_eq("addiu_pc", {16'd0, pc_out}, 32'h0100);
    check_eq("addiu_rw", {31'd0, reg_write_out}, 32'd1);
    drive(16'h6D7F, 16'h0102, 16'h0010, 16'h00AA, 2'd3, 3'd2, 1'b1, 1'b0);
    step();
    check_eq("li_op1", {16'd0, op1}, 32'h0000);
    check_eq("li_op2", {16'd0, op2}, 32'h007F);
    check_eq("li_opn", {16'd0, opn_out}, 32'h6D7F);
    check_eq("li_mw", {31'd0, mem_write_out}, 32'd1);
    in_valid = 1'b0;
    step();
    check_eq("drain_valid", {31'd0, out_valid}, 32'd0);
    check_eq("drain_opn", {16'd0, opn_out}, 32'h0800);
    check_eq("drain_mw", {31'd0, mem_write_out}, 32'd0);

    // operand mux table, one instruction per cycle
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(16'h0D9C, 16'h0042, 16'h1111, 16'h2222, 2'(i % 4), 3'(i), 1'b0, 1'b1);
      step();
      check_eq($sformatf("mux_op2_%0d", i), {16'd0, op2}, {16'd0, exp_op2[i]});
      check_eq($sformatf("mux_op1_%0d", i), {16'd0, op1}, {16'd0, exp_op1[i % 4]});
    end
    in_valid = 1'b0;
    step();

    // backpressure: three back-to-back inputs against a stalled EXE
    out_ready = 1'b0; in_valid = 1'b1;
    drive(16'h1001, 16'h0200, 16'hA001, 16'h0000, 2'd0, 3'd6, 1'b0, 1'b1);
    step();
    check_eq("bp1_opn", {16'd0, opn_out}, 32'h1001);
    check_eq("bp1_ready", {31'd0, in_ready}, 32'd1);
    drive(16'h1002, 16'h0202, 16'hA002, 16'h0000, 2'd0, 3'd6, 1'b0, 1'b1);
    step();
    check_eq("bp2_opn", {16'd0, opn_out}, 32'h1001);
    check_eq("bp2_ready", {31'd0, in_ready}, 32'd0);
    drive(16'h1003, 16'h0204, 16'hA003, 16'h0000, 2'd0, 3'd6, 1'b0, 1'b1);
    step();
    check_eq("bp3_hold_opn", {16'd0, opn_out}, 32'h1001);
    check_eq("bp3_hold_op1", {16'd0, op1}, 32'hA001);
    check_eq("bp3_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    check_eq("rel1_opn", {16'd0, opn_out}, 32'h1002);
    check_eq("rel1_op1", {16'd0, op1}, 32'hA002);
    check_eq("rel1_ready", {31'd0, in_ready}, 32'd1);
    step();
    check_eq("rel2_opn", {16'd0, opn_out}, 32'h1003);
    check_eq("rel2_op1", {16'd0, op1}, 32'hA003);
    in_valid = 1'b0;
    step();
    check_eq("rel3_valid", {31'd0, out_valid}, 32'd0);

    // flush with main and skid full and a new input presented
    out_ready = 1'b0; in_valid = 1'b1;
    drive(16'h2001, 16'h0300, 16'hB001, 16'h0000, 2'd0, 3'd0, 1'b1, 1'b1);
    step();
    drive(16'h2002, 16'h0302, 16'hB002, 16'h0000, 2'd0, 3'd0, 1'b1, 1'b1);
    step();
    check_eq("pre_flush_ready", {31'd0, in_ready}, 32'd0);
    drive(16'h2003, 16'h0304, 16'hB003, 16'h0000, 2'd0, 3'd0, 1'b1, 1'b1);
    flush = 1'b1; out_ready = 1'b1;
    step();
    check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
    check_eq("flush_opn", {16'd0, opn_out}, 32'h0800);
    check_eq("flush_rw", {31'd0, reg_write_out}, 32'd0);
    check_eq("flush_ready", {31'd0, in_ready}, 32'd1);
    check_eq("flush_op1", {16'd0, op1}, 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    check_eq("post_flush_valid", {31'd0, out_valid}, 32'd0);

    // bubble on empty stage, then on a held entry
    bubble = 1'b1; in_valid = 1'b1;
    drive(16'h3001, 16'h0400, 16'hC001, 16'h0000, 2'd0, 3'd0, 1'b0, 1'b1);
    step();
    check_eq("bub_empty_valid", {31'd0, out_valid}, 32'd0);
    check_eq("bub_empty_ready", {31'd0, in_ready}, 32'd1);
    bubble = 1'b0;
    step();
    check_eq("bub_accept_opn", {16'd0, opn_out}, 32'h3001);
    bubble = 1'b1;
    drive(16'h3002, 16'h0402, 16'hC002, 16'h0000, 2'd0, 3'd0, 1'b0, 1'b1);
    step();
    check_eq("bub_hold_opn", {16'd0, opn_out}, 32'h3001);
    check_eq("bub_hold_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    check_eq("bub_drain_valid", {31'd0, out_valid}, 32'd0);
    check_eq("bub_drain_opn", {16'd0, opn_out}, 32'h0800);
    bubble = 1'b0;

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(16'h4001, 16'h0500, 16'hD001, 16'h0000, 2'd0, 3'd7, 1'b0, 1'b1);
    step();
    drive(16'h4002, 16'h0502, 16'hD002, 16'h0000, 2'd0, 3'd7, 1'b0, 1'b1);
    step();
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_opn", {16'd0, opn_out}, 32'h0800);
    check_eq("arst_ready", {31'd0, in_ready}, 32'd1);
    check_eq("arst_op1", {16'd0, op1}, 32'd0);
    check_eq("arst_op2", {16'd0, op2}, 32'd0);
    step();
    rst = 1'b0;
    step();

`ifdef ID_EXE_FWD_EN
    out_ready = 1'b1; in_valid = 1'b1;
    drive(16'h5001, 16'h0600, 16'h0001, 16'h0002, 2'd0, 3'd0, 1'b0, 1'b1);
    rs1_addr = 4'd3; rs2_addr = 4'd5;
    fwd_exe_valid = 1'b1; fwd_exe_addr = 4'd3; fwd_exe_value = 16'h1234;
    fwd_mem_valid = 1'b1; fwd_mem_addr = 4'd3; fwd_mem_value = 16'h5678;
    step();
    check_eq("fwd_exe_op1", {16'd0, op1}, 32'h1234);
    check_eq("fwd_exe_op2", {16'd0, op2}, 32'h0002);
    fwd_exe_valid = 1'b0;
    step();
    check_eq("fwd_mem_op1", {16'd0, op1}, 32'h5678);
    fwd_mem_valid = 1'b0;
    in_valid = 1'b0;
    step();
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
